flot_inv_square: RTL and testbench
==================================

// Module: flot_inv_square
// PURPOSE
//   Sequential floating-point inverse-square unit: result = 1/(OP*OP), the inverse mapping of the
//   reciprocal-square-root path (recovers x from y = 1/sqrt(x)). Squares the mantissa, forms the
//   reciprocal by LUT seed plus Newton-Raphson iterations on a shared multiplier, renormalises,
//   repacks. Sits beside the isqrt unit in the ALU float datapath with a valid/ready handshake.
// PARAMETERS
//   WIDTH        16  total operand/result bits (sign + exponent + mantissa)
//   WIDTH_exp    4   exponent field bits; bias = 2**(WIDTH_exp-1)-1
//   WIDTH_mat    11  stored mantissa bits (hidden 1 implied)
//   LUT_addWidth 6   seed LUT address bits (top fraction bits of normalised square)
//   LUT_bits     12  seed LUT word width (format 0.LUT_bits, value ~1/d)
//   NR_ITERS     2   Newton-Raphson iterations, >=1
// PORTS
//   CLK       in   1      clock, all state on rising edge
//   RST       in   1      synchronous reset, active-high
//   CE        in   1      clock enable; low freezes all state and outputs
//   in_valid  in   1      OP/exce_in valid
//   in_ready  out  1      = CE && state==IDLE
//   OP        in   WIDTH  operand {sign, exp, mantissa}
//   exce_in   in   1      upstream exception, propagated
//   out_valid out  1      result/exce_out valid, held until out_ready
//   out_ready in   1      downstream accepts result
//   result    out  WIDTH  {1'b0, exp_out, mant_out}
//   exce_out  out  1      exce_in OR exponent out of range
// BEHAVIOUR
//   Reset: state=IDLE, out_valid=0, result=0, exce_out=0, in_ready=1 (when CE). RST mid-operation
//     aborts the operation; no result emitted. RST has priority over CE.
//   FSM: IDLE -(in_valid&&in_ready)-> SQ -> SEED -> {MUL1 -> MUL2} x NR_ITERS -> NORM -> OUT
//     -(out_ready)-> IDLE. OUT holds result stable; in_ready=0 outside IDLE (no overlap).
//   Latency: acceptance edge k -> out_valid high after edge k+3+2*NR_ITERS (7 for default).
//   SQ: m=1.mant (1.WIDTH_mat); s=m*m in [1,4); c=(s>=2); d=s>>c in [1,2), kept at F=WIDTH_mat+4
//     fraction bits, truncated. e_u = exp-bias (signed); E2 = 2*e_u + c.
//   SEED: x0 = LUT[d fraction top LUT_addWidth bits] ~ 1/d at bin midpoint, zero-extended to F bits.
//   MUL1: t = d*x (trunc to F). MUL2: x = x*(2-t) (trunc to F). One multiplier, time-shared.
//   NORM: if mant==0 (d==1 exactly): bypass, r=1, E_out=bias-E2, mant_out=0 (exact).
//     Else r=x in (0.5,1): mant_out = frac(2r) truncated to WIDTH_mat, E_out = bias-E2-1.
//   Sign: result sign always 0 (square is non-negative); input sign ignored.
//   Exponent: E_out computed signed, WIDTH_exp+2 bits. If E_out<0 or E_out>2**WIDTH_exp-1:
//     exce_out=1, result=0. Else exce_out=exce_in, result={0,E_out,mant_out}.
//   Exp field 0 treated as normal (no denormal/zero encoding), matching isqrt unit.
//   Accuracy: |error| <= 1 ulp of mant_out for default parameters; exact for power-of-two inputs.
//   CE low in any state: state, counters, datapath, out_valid frozen; handshakes not taken.
//   OUT with out_ready=1 and in_valid=1 same cycle: result retires, new OP not accepted until IDLE.
// TESTING
//   OP=0x3800 (1.0) -> result 0x3800, exce_out=0, out_valid at edge k+7.
//   OP=0x4000 (2.0) -> 0x2800 (0.25); OP=0xC000 (-2.0) -> 0x2800; OP=0x3000 (0.5) -> 0x4800 (4.0).
//   OP=0x3C00 (1.5) -> 0x2E38 +/-1 ulp (0.4444); random sweep vs real model, all within 1 ulp.
//   OP=0x0000 (2^-7) -> exce_out=1, result=0; OP=0x7800 (2^8) -> exce_out=1; exce_in=1 with 0x3800 -> exce_out=1.
//   out_ready held low 5 cycles in OUT -> result/out_valid stable; CE low 3 cycles mid-ITER -> latency +3, same result.
//   RST asserted at MUL1 -> next cycle IDLE, out_valid=0, in_ready=1; following OP=0x4000 -> 0x2800.

Source files
------------

// File: rtl/flot_inv_square.sv
// Sequential floating-point inverse square, result = 1/(OP*OP).
// The mantissa square and the Newton-Raphson reciprocal share one multiplier.
module flot_inv_square #(
  parameter int WIDTH        = 16,
  parameter int WIDTH_exp    = 4,
  parameter int WIDTH_mat    = 11,
  parameter int LUT_addWidth = 6,
  parameter int LUT_bits     = 12,
  parameter int NR_ITERS     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] OP,
  input  logic             exce_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             exce_out
);

  localparam int F     = WIDTH_mat + 4;
  localparam int DW    = F + 2;
  localparam int PW    = 2 * DW;
  localparam int EW    = WIDTH_exp + 2;
  localparam int BIAS  = 2 ** (WIDTH_exp - 1) - 1;
  localparam int LUT_N = 2 ** LUT_addWidth;
  localparam int ITW   = (NR_ITERS > 1) ? $clog2(NR_ITERS) : 1;
  localparam logic [DW-1:0] TWO = DW'(1) << (F + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    SEED = 3'd2,
    MUL1 = 3'd3,
    MUL2 = 3'd4,
    NORM = 3'd5,
    OUT  = 3'd6
  } state_t;

  // Seed word ~ 1/d at the centre of each bin, scaled to 0.LUT_bits.
  function automatic logic [LUT_bits-1:0] seed_val(input int idx);
    int num;
    int den;
    den = 2 * LUT_N + 2 * idx + 1;
    num = 1 << (LUT_bits + LUT_addWidth + 1);
    return LUT_bits'((num + den / 2) / den);
  endfunction

  logic [LUT_bits-1:0] seed_lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    assign seed_lut[gi] = seed_val(gi);
  end

  state_t               state_q, state_d;
  logic [ITW-1:0]       it_q, it_d;
  logic [WIDTH_exp-1:0] exp_q, exp_d;
  logic [WIDTH_mat-1:0] mant_q, mant_d;
  logic                 exin_q, exin_d;
  logic                 c_q, c_d;
  logic [DW-1:0]        d_q, d_d;
  logic [DW-1:0]        x_q, x_d;
  logic [DW-1:0]        t_q, t_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exce_out_q, exce_out_d;

  logic [DW-1:0]        mul_a, mul_b;
  logic [PW-1:0]        prod;
  logic [DW-1:0]        m_ext;
  logic [DW-1:0]        x0;
  logic                 bypass;
  logic [EW-1:0]        e_out_u;
  logic                 range_bad;
  logic [WIDTH_mat-1:0] mant_out;
  logic                 unused_bits;

  assign m_ext = {{(DW-WIDTH_mat-1){1'b0}}, 1'b1, mant_q} << (F - WIDTH_mat);
  assign x0    = {{(DW-LUT_bits){1'b0}}, seed_lut[d_q[F-1 -: LUT_addWidth]]} << (F - LUT_bits);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      SQ:   begin mul_a = m_ext; mul_b = m_ext;     end
      MUL1: begin mul_a = d_q;   mul_b = x_q;       end
      MUL2: begin mul_a = x_q;   mul_b = TWO - t_q; end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  // Exponent: bias - (2*(exp-bias) + c) - 1, folded into one modular subtraction.
  assign bypass    = (d_q[F-1:0] == '0);
  assign e_out_u   = EW'(3 * BIAS) - {1'b0, exp_q, 1'b0}
                   - {{(EW-1){1'b0}}, c_q} - {{(EW-1){1'b0}}, ~bypass};
  assign range_bad = e_out_u[EW-1] | (e_out_u[EW-2:WIDTH_exp] != '0);

  always_comb begin
    mant_out = '0;
    if (!bypass) begin
      if (x_q[F]) mant_out = '1;
      else        mant_out = x_q[F-2 -: WIDTH_mat];
    end
  end

  always_comb begin
    state_d    = state_q;
    it_d       = it_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    exin_d     = exin_q;
    c_d        = c_q;
    d_d        = d_q;
    x_d        = x_q;
    t_d        = t_q;
    result_d   = result_q;
    exce_out_d = exce_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = OP[WIDTH-2 -: WIDTH_exp];
          mant_d  = OP[WIDTH_mat-1:0];
          exin_d  = exce_in;
          state_d = SQ;
        end
      end
      SQ: begin
        c_d     = prod[2*F+1];
        d_d     = prod[2*F+1] ? {1'b0, prod[2*F+1:F+1]} : {1'b0, prod[2*F:F]};
        state_d = SEED;
      end
      SEED: begin
        x_d     = x0;
        it_d    = '0;
        state_d = MUL1;
      end
      MUL1: begin
        t_d     = prod[2*F+1:F];
        state_d = MUL2;
      end
      MUL2: begin
        x_d = prod[2*F+1:F];
        if (it_q == ITW'(NR_ITERS - 1)) begin
          state_d = NORM;
        end else begin
          it_d    = it_q + ITW'(1);
          state_d = MUL1;
        end
      end
      NORM: begin
        exce_out_d = exin_q | range_bad;
        result_d   = range_bad ? '0 : {1'b0, e_out_u[WIDTH_exp-1:0], mant_out};
        state_d    = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      it_q       <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
      exin_q     <= 1'b0;
      c_q        <= 1'b0;
      d_q        <= '0;
      x_q        <= '0;
      t_q        <= '0;
      result_q   <= '0;
      exce_out_q <= 1'b0;
    end else if (CE) begin
      state_q    <= state_d;
      it_q       <= it_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      exin_q     <= exin_d;
      c_q        <= c_d;
      d_q        <= d_d;
      x_q        <= x_d;
      t_q        <= t_d;
      result_q   <= result_d;
      exce_out_q <= exce_out_d;
    end
  end

  assign in_ready  = CE && (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign exce_out  = exce_out_q;

  // Sign is irrelevant to a square; product bits outside the 2.F window are never needed.
  assign unused_bits = ^{OP[WIDTH-1], prod[PW-1:2*F+2], prod[F-1:0]};

endmodule

// File: tb/tb_flot_inv_square.sv
// Scoreboard bench for flot_inv_square: directed cases, handshake/CE/reset
// corner cases and a random sweep against a real-number model.
module tb_flot_inv_square;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] OP;
  logic        exce_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        exce_out;

  always #5 CLK = ~CLK;

  flot_inv_square dut (
    .CLK      (CLK),
    .RST      (RST),
    .CE       (CE),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OP       (OP),
    .exce_in  (exce_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .exce_out (exce_out)
  );

  typedef struct {
    string tag;
    int    want;
    bit    want_exc;
    int    tol;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check_val(input string tag, input int got, input int want, input int tol);
    int diff;
    total++;
    diff = got - want;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h tol=%0d", tag, got, want, tol);
    end
  endtask

  // 1/(v*v) as the 15-bit exp:mant index, mantissa truncated.
  function automatic int model_res(input logic [15:0] op);
    real v;
    real y;
    int  ef;
    v  = 1.0 + real'(op[10:0]) / 2048.0;
    ef = -2 * (int'(op[14:11]) - 7);
    y  = 1.0 / (v * v);
    while (y < 1.0)  begin y = y * 2.0; ef--; end
    while (y >= 2.0) begin y = y / 2.0; ef++; end
    return (ef + 7) * 2048 + $rtoi((y - 1.0) * 2048.0);
  endfunction

  always @(negedge CLK) begin : mon
    sb_t e;
    if (!RST && CE && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", sb_q.size(), 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_val({e.tag, "_res"}, int'(result), e.want, e.tol);
        check_val({e.tag, "_exc"}, int'(exce_out), int'(e.want_exc), 0);
        $display("txn %s: result=0x%04h exce=%0b want=0x%04h", e.tag, result, exce_out, e.want);
      end
    end
  end

  task automatic do_op(input logic [15:0] op, input logic ei, input int want, input bit want_exc,
                       input int tol, input string tag, input int want_lat, input int stall_at,
                       input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge CLK); #1; n++; end
    check_val({tag, "_inrdy"}, int'(in_ready), 1, 0);
    sb_q.push_back('{tag, want, want_exc, tol});
    OP       = op;
    exce_in  = ei;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    OP       = 16'($urandom);
    exce_in  = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      if (stall_at > 0 && n == stall_at)     CE = 1'b0;
      if (stall_at > 0 && n == stall_at + 3) CE = 1'b1;
      @(posedge CLK); #1;
      n++;
    end
    CE = 1'b1;
    if (want_lat > 0) check_val({tag, "_lat"}, n, want_lat, 0);
    for (int i = 0; i < hold; i++) begin
      check_val({tag, "_hold_v"}, int'(out_valid), 1, 0);
      check_val({tag, "_hold_r"}, int'(result), want, 0);
      check_val({tag, "_hold_busy"}, int'(in_ready), 0, 0);
      @(posedge CLK); #1;
    end
    // Offer a new operand in the retire cycle; it must not be taken.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_val({tag, "_retired"}, int'(out_valid), 0, 0);
    check_val({tag, "_idle"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    logic [15:0] rop;
    logic        rei;
    int          seen;
    RST       = 1'b1;
    CE        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    OP        = 16'h0000;
    exce_in   = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_val("rst_ov",  int'(out_valid), 0, 0);
    check_val("rst_res", int'(result),    0, 0);
    check_val("rst_exc", int'(exce_out),  0, 0);
    check_val("rst_rdy", int'(in_ready),  1, 0);

    do_op(16'h3800, 1'b0, 16'h3800, 1'b0, 0, "one",      7,  0, 0);
    do_op(16'h4000, 1'b0, 16'h2800, 1'b0, 0, "two",      7,  0, 0);
    do_op(16'hC000, 1'b0, 16'h2800, 1'b0, 0, "neg_two",  0,  0, 0);
    do_op(16'h3000, 1'b0, 16'h4800, 1'b0, 0, "half",     0,  0, 0);
    do_op(16'h3C00, 1'b0, 16'h2E38, 1'b0, 1, "one_half", 0,  0, 0);
    do_op(16'h0000, 1'b0, 16'h0000, 1'b1, 0, "exp_hi",   0,  0, 0);
    do_op(16'h7800, 1'b0, 16'h0000, 1'b1, 0, "exp_lo",   0,  0, 0);
    do_op(16'h3800, 1'b1, 16'h3800, 1'b1, 0, "exce_in",  0,  0, 0);
    do_op(16'h4000, 1'b0, 16'h2800, 1'b0, 0, "hold",     7,  0, 5);
    do_op(16'h3C00, 1'b0, 16'h2E38, 1'b0, 1, "ce_stall", 10, 3, 0);

    // Abort an operation in MUL1 with a reset pulse.
    OP       = 16'h3800;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_val("abort_ov",  int'(out_valid), 0, 0);
    check_val("abort_rdy", int'(in_ready),  1, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge CLK); #1;
    end
    check_val("abort_noout", seen, 0, 0);
    do_op(16'h4000, 1'b0, 16'h2800, 1'b0, 0, "after_rst", 7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rop = {1'($urandom), 4'($urandom_range(9, 4)), 11'($urandom)};
      rei = 1'($urandom);
      do_op(rop, rei, model_res(rop), rei, (rop[10:0] == 11'd0) ? 0 : 1,
            $sformatf("rnd%0d_%04h", i, rop), 0, 0, 0);
    end

    check_val("sb_drained", sb_q.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
